// File: rtl/axi_aw_w_arbiter.sv
// Round-robin AW arbiter for one subordinate write port. A route FIFO remembers grant
// order so each W burst is steered to the manager that won the matching AW.
module axi_aw_w_arbiter #(
    parameter int NUM_MST = 4,
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int DATA_W  = 32,
    parameter int W_DEPTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_MST-1:0]         s_awvalid,
    output logic [NUM_MST-1:0]         s_awready,
    input  logic [NUM_MST*ADDR_W-1:0]  s_awaddr,
    input  logic [NUM_MST*ID_W-1:0]    s_awid,
    input  logic [NUM_MST*8-1:0]       s_awlen,
    input  logic [NUM_MST*3-1:0]       s_awsize,
    input  logic [NUM_MST*2-1:0]       s_awburst,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [ADDR_W-1:0]          m_awaddr,
    output logic [ID_W-1:0]            m_awid,
    output logic [7:0]                 m_awlen,
    output logic [2:0]                 m_awsize,
    output logic [1:0]                 m_awburst,
    input  logic [NUM_MST-1:0]         s_wvalid,
    output logic [NUM_MST-1:0]         s_wready,
    input  logic [NUM_MST*DATA_W-1:0]  s_wdata,
    input  logic [NUM_MST*DATA_W/8-1:0] s_wstrb,
    input  logic [NUM_MST-1:0]         s_wlast,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    output logic [DATA_W-1:0]          m_wdata,
    output logic [DATA_W/8-1:0]        m_wstrb,
    output logic                       m_wlast,
    output logic                       w_busy
);
    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a held valid keeps its payload stable.
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(NUM_MST);
    localparam int PTR_W  = $clog2(W_DEPTH);
    localparam int CNT_W  = $clog2(W_DEPTH) + 1;

    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  fifo_mem [W_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] aw_addr_arr  [NUM_MST];
    logic [ID_W-1:0]   aw_id_arr    [NUM_MST];
    logic [7:0]        aw_len_arr   [NUM_MST];
    logic [2:0]        aw_size_arr  [NUM_MST];
    logic [1:0]        aw_burst_arr [NUM_MST];
    logic [DATA_W-1:0] w_data_arr   [NUM_MST];
    logic [STRB_W-1:0] w_strb_arr   [NUM_MST];

    logic              found;
    logic [IDX_W-1:0]  win;
    logic [IDX_W-1:0]  ptr_nxt;
    logic              fifo_full;
    logic              grant;
    logic              pop;
    logic [IDX_W-1:0]  head;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            aw_addr_arr[i]  = s_awaddr[i*ADDR_W +: ADDR_W];
            aw_id_arr[i]    = s_awid[i*ID_W +: ID_W];
            aw_len_arr[i]   = s_awlen[i*8 +: 8];
            aw_size_arr[i]  = s_awsize[i*3 +: 3];
            aw_burst_arr[i] = s_awburst[i*2 +: 2];
            w_data_arr[i]   = s_wdata[i*DATA_W +: DATA_W];
            w_strb_arr[i]   = s_wstrb[i*STRB_W +: STRB_W];
        end
    end

    // Scan ptr, ptr+1, ... wrapping at NUM_MST; first requester wins.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_MST) j = j - NUM_MST;
            if (!found && s_awvalid[IDX_W'(j)]) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    assign ptr_nxt   = (win == IDX_W'(NUM_MST - 1)) ? '0 : win + IDX_W'(1);
    assign fifo_full = (count == CNT_W'(W_DEPTH));
    // Reset gates the grant so s_awready stays low while aresetn is asserted.
    assign grant     = aresetn && (!m_awvalid || m_awready) && !fifo_full && found;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            s_awready[i] = grant && (win == IDX_W'(i));
        end
    end

    assign head     = fifo_mem[rd_ptr];
    assign w_busy   = (count != '0);
    assign m_wvalid = w_busy && s_wvalid[head];
    assign m_wdata  = w_data_arr[head];
    assign m_wstrb  = w_strb_arr[head];
    assign m_wlast  = w_busy && s_wlast[head];
    assign pop      = m_wvalid && m_wready && m_wlast;

    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            s_wready[i] = w_busy && m_wready && (head == IDX_W'(i));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            m_awvalid <= 1'b0;
            m_awaddr  <= '0;
            m_awid    <= '0;
            m_awlen   <= '0;
            m_awsize  <= '0;
            m_awburst <= '0;
            for (int i = 0; i < W_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (grant) begin
                ptr              <= ptr_nxt;
                m_awvalid        <= 1'b1;
                m_awaddr         <= aw_addr_arr[win];
                m_awid           <= aw_id_arr[win];
                m_awlen          <= aw_len_arr[win];
                m_awsize         <= aw_size_arr[win];
                m_awburst        <= aw_burst_arr[win];
                fifo_mem[wr_ptr] <= win;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end else if (m_awready) begin
                m_awvalid <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(grant) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_axi_aw_w_arbiter.sv
// Directed bench for axi_aw_w_arbiter: arbitration order, AW stall, W steering,
// route FIFO full/pop interaction and asynchronous reset.
module tb_axi_aw_w_arbiter;
    localparam int NUM_MST = 4;
    localparam int ADDR_W  = 32;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 32;
    localparam int W_DEPTH = 4;

    logic                        aclk;
    logic                        aresetn;
    logic [NUM_MST-1:0]          s_awvalid;
    logic [NUM_MST-1:0]          s_awready;
    logic [NUM_MST*ADDR_W-1:0]   s_awaddr;
    logic [NUM_MST*ID_W-1:0]     s_awid;
    logic [NUM_MST*8-1:0]        s_awlen;
    logic [NUM_MST*3-1:0]        s_awsize;
    logic [NUM_MST*2-1:0]        s_awburst;
    logic                        m_awvalid;
    logic                        m_awready;
    logic [ADDR_W-1:0]           m_awaddr;
    logic [ID_W-1:0]             m_awid;
    logic [7:0]                  m_awlen;
    logic [2:0]                  m_awsize;
    logic [1:0]                  m_awburst;
    logic [NUM_MST-1:0]          s_wvalid;
    logic [NUM_MST-1:0]          s_wready;
    logic [NUM_MST*DATA_W-1:0]   s_wdata;
    logic [NUM_MST*DATA_W/8-1:0] s_wstrb;
    logic [NUM_MST-1:0]          s_wlast;
    logic                        m_wvalid;
    logic                        m_wready;
    logic [DATA_W-1:0]           m_wdata;
    logic [DATA_W/8-1:0]         m_wstrb;
    logic                        m_wlast;
    logic                        w_busy;

    int n_tests;
    int n_fail;
    logic [1:0] exp_q[$];

    axi_aw_w_arbiter #(
        .NUM_MST(NUM_MST), .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .W_DEPTH(W_DEPTH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .w_busy(w_busy)
    );

    // Clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Driver tasks
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_aw(input int i, input logic [31:0] addr, input logic [3:0] id,
                          input logic [7:0] len);
        s_awvalid[i]          = 1'b1;
        s_awaddr[i*ADDR_W +: ADDR_W] = addr;
        s_awid[i*ID_W +: ID_W] = id;
        s_awlen[i*8 +: 8]     = len;
        s_awsize[i*3 +: 3]    = 3'd2;
        s_awburst[i*2 +: 2]   = 2'd1;
    endtask

    task automatic set_w(input int i, input logic [31:0] data, input logic last);
        s_wvalid[i]                  = 1'b1;
        s_wdata[i*DATA_W +: DATA_W]  = data;
        s_wstrb[i*4 +: 4]            = 4'hF;
        s_wlast[i]                   = last;
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awid = '0; s_awlen = '0; s_awsize = '0;
        s_awburst = '0; s_wvalid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = '0;
        m_awready = 1'b0; m_wready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 1'b0;
        s_awvalid = 4'b1111;
        s_wvalid  = 4'b1111;
        m_awready = 1'b1;
        m_wready  = 1'b1;
        tick();
        n_tests++;
        if (s_awready !== 4'b0000) begin n_fail++; $display("FAIL reset_awready: got %b exp 0000", s_awready); end
        n_tests++;
        if (m_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_awvalid: got %b exp 0", m_awvalid); end
        n_tests++;
        if (m_awaddr !== 32'h0) begin n_fail++; $display("FAIL reset_m_awaddr: got %h exp 0", m_awaddr); end
        n_tests++;
        if (w_busy !== 1'b0 || m_wvalid !== 1'b0 || s_wready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_w: busy %b wvalid %b wready %b exp 0 0 0000", w_busy, m_wvalid, s_wready);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        set_aw(2, 32'h1000, 4'h5, 8'd3);
        #1;
        n_tests++;
        if (s_awready !== 4'b0100) begin n_fail++; $display("FAIL single_awready: got %b exp 0100", s_awready); end
        tick();
        s_awvalid = '0;
        #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h1000 || m_awid !== 4'h5 || m_awlen !== 8'd3
            || m_awsize !== 3'd2 || m_awburst !== 2'd1) begin
            n_fail++;
            $display("FAIL single_aw_payload: got v%b a%h id%h len%0d sz%0d b%0d exp v1 a1000 id5 len3 sz2 b1",
                     m_awvalid, m_awaddr, m_awid, m_awlen, m_awsize, m_awburst);
        end
        n_tests++;
        if (w_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b exp 1", w_busy); end
        tick();
        n_tests++;
        if (m_awvalid !== 1'b0) begin n_fail++; $display("FAIL single_awvalid_drop: got %b exp 0", m_awvalid); end
        for (int b = 0; b < 4; b++) begin
            set_w(2, 32'hA0 + b, (b == 3));
            set_w(0, 32'hEE, 1'b1);
            #1;
            n_tests++;
            if (m_wvalid !== 1'b1 || m_wdata !== 32'hA0 + b || m_wlast !== (b == 3) || s_wready !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_w_beat%0d: got v%b d%h l%b rdy%b exp v1 d%h l%b rdy0100",
                         b, m_wvalid, m_wdata, m_wlast, s_wready, 32'hA0 + b, (b == 3));
            end
            tick();
        end
        #1;
        n_tests++;
        if (w_busy !== 1'b0 || m_wvalid !== 1'b0 || s_wready !== 4'b0000) begin
            n_fail++; $display("FAIL single_pop: busy %b wvalid %b wready %b exp 0 0 0000", w_busy, m_wvalid, s_wready);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        apply_reset();
        m_awready = 1'b1;
        for (int i = 0; i < 4; i++) set_aw(i, 32'h100 * i, 4'(i), 8'd0);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_tests++;
            if (s_awready !== 4'(1 << k)) begin
                n_fail++; $display("FAIL b2b_grant%0d: got %b exp %b", k, s_awready, 4'(1 << k));
            end
            exp_q.push_back(2'(k));
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (m_awvalid !== 1'b1 || m_awaddr !== 32'h100 * e || m_awid !== 4'(e)) begin
                n_fail++; $display("FAIL b2b_payload%0d: got v%b a%h id%h exp v1 a%h id%h",
                                   k, m_awvalid, m_awaddr, m_awid, 32'h100 * e, 4'(e));
            end
        end
        n_tests++;
        if (s_awready !== 4'b0000) begin n_fail++; $display("FAIL full_no_grant0: got %b exp 0000", s_awready); end
        tick();
        n_tests++;
        if (s_awready !== 4'b0000 || m_awvalid !== 1'b0) begin
            n_fail++; $display("FAIL full_no_grant1: got rdy%b v%b exp 0000 0", s_awready, m_awvalid);
        end
        // Last beat of head burst and pending AW in the same cycle while full.
        m_wready = 1'b1;
        set_w(0, 32'hD0, 1'b1);
        #1;
        n_tests++;
        if (s_awready !== 4'b0000 || s_wready !== 4'b0001 || m_wvalid !== 1'b1 || m_wdata !== 32'hD0) begin
            n_fail++; $display("FAIL full_pop_same_cycle: got rdy%b wrdy%b wv%b d%h exp 0000 0001 1 d0",
                               s_awready, s_wready, m_wvalid, m_wdata);
        end
        tick();
        s_wvalid = '0;
        s_wlast  = '0;
        #1;
        n_tests++;
        if (s_awready !== 4'b0001) begin n_fail++; $display("FAIL full_regrant: got %b exp 0001", s_awready); end
        tick();
        n_tests++;
        if (s_awready !== 4'b0000 || m_awaddr !== 32'h0 || w_busy !== 1'b1) begin
            n_fail++; $display("FAIL full_again: got rdy%b a%h busy%b exp 0000 0 1", s_awready, m_awaddr, w_busy);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        apply_reset();
        set_aw(1, 32'h2000, 4'h1, 8'd0);
        #1;
        n_tests++;
        if (s_awready !== 4'b0010) begin n_fail++; $display("FAIL stall_first: got %b exp 0010", s_awready); end
        tick();
        s_awvalid = '0;
        set_aw(0, 32'h3000, 4'h0, 8'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (s_awready !== 4'b0000 || m_awvalid !== 1'b1 || m_awaddr !== 32'h2000 || m_awid !== 4'h1) begin
                n_fail++; $display("FAIL stall_hold%0d: got rdy%b v%b a%h id%h exp 0000 1 2000 1",
                                   c, s_awready, m_awvalid, m_awaddr, m_awid);
            end
            tick();
        end
        m_awready = 1'b1;
        #1;
        n_tests++;
        if (s_awready !== 4'b0001) begin n_fail++; $display("FAIL stall_resume: got %b exp 0001", s_awready); end
        tick();
        s_awvalid = '0;
        #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h3000) begin
            n_fail++; $display("FAIL stall_next_payload: got v%b a%h exp 1 3000", m_awvalid, m_awaddr);
        end
        tick();
        n_tests++;
        if (m_awvalid !== 1'b0) begin n_fail++; $display("FAIL stall_drop: got %b exp 0", m_awvalid); end
        clear_inputs();
    endtask

    task automatic test_w_before_aw();
        apply_reset();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        set_w(3, 32'h33, 1'b1);
        set_aw(1, 32'h4000, 4'h1, 8'd1);
        #1;
        n_tests++;
        if (s_awready !== 4'b0010 || s_wready !== 4'b0000 || m_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL early_w_empty: got rdy%b wrdy%b wv%b exp 0010 0000 0", s_awready, s_wready, m_wvalid);
        end
        tick();
        s_awvalid = '0;
        set_aw(3, 32'h5000, 4'h3, 8'd0);
        set_w(1, 32'h11, 1'b0);
        #1;
        n_tests++;
        if (s_awready !== 4'b1000 || s_wready !== 4'b0010 || m_wdata !== 32'h11 || m_wlast !== 1'b0) begin
            n_fail++; $display("FAIL early_w_beat0: got rdy%b wrdy%b d%h l%b exp 1000 0010 11 0",
                               s_awready, s_wready, m_wdata, m_wlast);
        end
        tick();
        s_awvalid = '0;
        set_w(1, 32'h12, 1'b1);
        #1;
        n_tests++;
        if (s_wready !== 4'b0010 || m_wdata !== 32'h12 || m_wlast !== 1'b1) begin
            n_fail++; $display("FAIL early_w_beat1: got wrdy%b d%h l%b exp 0010 12 1", s_wready, m_wdata, m_wlast);
        end
        tick();
        s_wvalid[1] = 1'b0;
        s_wlast[1]  = 1'b0;
        #1;
        n_tests++;
        if (s_wready !== 4'b1000 || m_wvalid !== 1'b1 || m_wdata !== 32'h33 || m_wlast !== 1'b1) begin
            n_fail++; $display("FAIL early_w_flow: got wrdy%b wv%b d%h l%b exp 1000 1 33 1",
                               s_wready, m_wvalid, m_wdata, m_wlast);
        end
        tick();
        s_wvalid = '0;
        #1;
        n_tests++;
        if (w_busy !== 1'b0) begin n_fail++; $display("FAIL early_w_done: got %b exp 0", w_busy); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_awready = 1'b1;
        m_wready  = 1'b1;
        set_aw(2, 32'h6000, 4'h2, 8'd3);
        tick();
        s_awvalid = '0;
        for (int b = 0; b < 2; b++) begin
            set_w(2, 32'h60 + b, 1'b0);
            tick();
        end
        set_w(2, 32'h62, 1'b0);
        set_aw(1, 32'h7100, 4'h1, 8'd0);
        set_aw(3, 32'h7300, 4'h3, 8'd0);
        #1;
        n_tests++;
        if (m_wvalid !== 1'b1 || m_wdata !== 32'h62 || m_awaddr !== 32'h6000) begin
            n_fail++; $display("FAIL mid_pre: got wv%b d%h a%h exp 1 62 6000", m_wvalid, m_wdata, m_awaddr);
        end
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (m_wvalid !== 1'b0 || s_wready !== 4'b0000 || w_busy !== 1'b0 || s_awready !== 4'b0000
            || m_awvalid !== 1'b0 || m_awaddr !== 32'h0 || m_awid !== 4'h0 || m_awlen !== 8'h0) begin
            n_fail++; $display("FAIL mid_reset: got wv%b wrdy%b busy%b rdy%b v%b a%h id%h len%h exp all 0",
                               m_wvalid, s_wready, w_busy, s_awready, m_awvalid, m_awaddr, m_awid, m_awlen);
        end
        tick();
        s_wvalid = '0;
        aresetn  = 1'b1;
        #1;
        n_tests++;
        if (s_awready !== 4'b0010) begin n_fail++; $display("FAIL mid_after_grant: got %b exp 0010", s_awready); end
        tick();
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awaddr !== 32'h7100) begin
            n_fail++; $display("FAIL mid_after_payload: got v%b a%h exp 1 7100", m_awvalid, m_awaddr);
        end
        clear_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();
        aresetn = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_w_before_aw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
